// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller: parameter defaults,
// sweep-mode constants and the controller state encoding.
package dds_pkg;

  localparam int unsigned PW_DEF  = 8;
  localparam int unsigned DWW_DEF = 16;

  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_TRIANGLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: loads the hold length, counts while enabled and flags
// expiry when it reaches zero.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int unsigned DWW = DWW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           en,
  input  logic [DWW-1:0] load_val,
  output logic           expired_c
);

  logic [DWW-1:0] cnt_q;

  // Load has priority so a fresh inc value always starts a full dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWW'(1);
    end
  end

  assign expired_c = en && (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Phase-increment sweep controller feeding a DDS accumulator: single up-sweep
// or continuous triangle between a start and stop increment with a per-step dwell.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned PW  = PW_DEF,
  parameter int unsigned DWW = DWW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [PW-1:0]  cfg_start,
  input  logic [PW-1:0]  cfg_stop,
  input  logic [PW-1:0]  cfg_step,
  input  logic [DWW-1:0] cfg_dwell,
  input  logic           cfg_mode,
  input  logic           start,
  input  logic           abort,
  output logic [PW-1:0]  inc,
  output logic           inc_valid,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
);

  sweep_state_t   state_q, state_d;
  logic [PW-1:0]  inc_q, inc_d;
  logic           inc_valid_q, inc_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           cfg_err_q, cfg_err_d;
  logic           cfg_loaded_q, cfg_loaded_d;
  logic [PW-1:0]  start_q, start_d;
  logic [PW-1:0]  stop_q, stop_d;
  logic [PW-1:0]  step_q, step_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic           mode_q, mode_d;

  logic           accept;
  logic           dwell_load;
  logic           dwell_exp;
  logic           sweeping;

  logic [PW:0]        up_sum;
  logic [PW-1:0]      up_next;
  logic signed [PW:0] dn_diff;
  logic [PW-1:0]      dn_next;

  // Saturating step arithmetic one bit wider than inc so it never wraps.
  assign up_sum  = {1'b0, inc_q} + {1'b0, step_q};
  assign up_next = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[PW-1:0];
  assign dn_diff = $signed({1'b0, inc_q}) - $signed({1'b0, step_q});
  assign dn_next = (dn_diff < $signed({1'b0, start_q})) ? start_q : dn_diff[PW-1:0];

  assign cfg_ready = (state_q == ST_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign sweeping  = (state_q == ST_UP) || (state_q == ST_DOWN);

  dds_dwell_timer #(
    .DWW (DWW)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .load      (dwell_load),
    .en        (sweeping),
    .load_val  (dwell_q),
    .expired_c (dwell_exp)
  );

  // State, sweep and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inc_q        <= '0;
      inc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_loaded_q <= 1'b0;
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      inc_q        <= inc_d;
      inc_valid_q  <= inc_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      cfg_loaded_q <= cfg_loaded_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      mode_q       <= mode_d;
    end
  end

  // Next-state, next-inc and next-output logic.
  always_comb begin
    state_d      = state_q;
    inc_d        = inc_q;
    cfg_err_d    = cfg_err_q;
    cfg_loaded_d = cfg_loaded_q;
    start_d      = start_q;
    stop_d       = stop_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    mode_d       = mode_q;
    inc_valid_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    dwell_load   = 1'b0;

    if (accept) begin
      start_d      = cfg_start;
      stop_d       = cfg_stop;
      step_d       = cfg_step;
      dwell_d      = cfg_dwell;
      mode_d       = cfg_mode;
      cfg_loaded_d = 1'b1;
      cfg_err_d    = (cfg_step == '0) || (cfg_start > cfg_stop);
    end

    unique case (state_q)
      ST_IDLE: begin
        inc_d = '0;
        // Start is judged against the configuration already held, not one arriving now.
        if (start && cfg_loaded_q && !cfg_err_q) begin
          state_d = ST_UP;
          inc_d   = start_q;
        end
      end
      ST_UP: begin
        if (dwell_exp) begin
          if (inc_q != stop_q) begin
            inc_d = up_next;
          end else if (mode_q == MODE_SINGLE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DOWN;
            inc_d   = dn_next;
          end
        end
      end
      ST_DOWN: begin
        if (dwell_exp) begin
          if (inc_q != start_q) begin
            inc_d = dn_next;
          end else begin
            state_d = ST_UP;
            inc_d   = up_next;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        inc_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        inc_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      inc_d   = '0;
    end

    inc_valid_d = (state_d == ST_UP) || (state_d == ST_DOWN);
    busy_d      = inc_valid_d;
    done_d      = (state_d == ST_DONE);
    dwell_load  = (state_d != state_q) || (inc_d != inc_q);
  end

  assign inc       = inc_q;
  assign inc_valid = inc_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PW, default 8, phase-increment width.
REQ-002 SHALL have parameter DWW, default 16, dwell-count width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  config offer.
REQ-006 SHALL have port cfg_ready  output  1  config accepted when high with cfg_valid.
REQ-007 SHALL have port cfg_start  input  PW  sweep lower increment.
REQ-008 SHALL have port cfg_stop  input  PW  sweep upper increment.
REQ-009 SHALL have port cfg_step  input  PW  increment delta per dwell.
REQ-010 SHALL have port cfg_dwell  input  DWW  hold length minus one, in cycles.
REQ-011 SHALL have port cfg_mode  input  1  0 = single up-sweep, 1 = continuous triangle.
REQ-012 SHALL have port start  input  1  begin sweep (level sampled).
REQ-013 SHALL have port abort  input  1  stop sweep immediately.
REQ-014 SHALL have port inc  output  PW  phase increment to the DDS accumulator.
REQ-015 SHALL have port inc_valid  output  1  DDS accumulate enable.
REQ-016 SHALL have port busy, done, cfg_err  output  1 each  status; done is a one-cycle pulse; cfg_err is sticky.

Function
REQ-017 SHALL implement the states IDLE, UP, DOWN and DONE.
REQ-018 SHALL drive cfg_ready=1 only in IDLE and SHALL register all cfg_* fields on cfg_valid&&cfg_ready.
REQ-019 SHALL set cfg_err=1 on accept if cfg_step==0 or cfg_start>cfg_stop, and clear it on accept otherwise.
REQ-020 SHALL, in IDLE with a valid accepted config, cfg_err==0, start==1 and abort==0, enter UP at the next edge with inc=cfg_start, inc_valid=1 and busy=1.
REQ-021 SHALL ignore start while no config has been accepted, while cfg_err==1, or while in any non-IDLE state.
REQ-022 SHALL hold each inc value for exactly cfg_dwell+1 cycles (dwell expiry).
REQ-023 SHALL, in UP at dwell expiry, set inc=min(inc+step, stop) computed at PW+1 bits, with no wrap, when inc != stop.
REQ-024 SHALL, in UP at dwell expiry with inc==stop, enter DONE in mode 0 and enter DOWN in mode 1.
REQ-025 SHALL, in DOWN at dwell expiry, set inc=max(inc-step, start) computed at PW+1 bits signed, with no underflow, when inc != start.
REQ-026 SHALL, in DOWN at dwell expiry with inc==start, enter UP.
REQ-027 SHALL make DONE last one cycle with done=1, inc_valid=0 and inc holding stop, then return to IDLE.
REQ-028 SHALL drive inc=0, inc_valid=0 and busy=0 in IDLE.
REQ-029 SHALL, when abort==1 in any state, go to IDLE at the next edge with inc=0 and no done pulse; abort has priority over start and over dwell expiry.
REQ-030 SHALL, when start==stop, hold that value and then complete in mode 0, or alternate UP/DOWN at a constant inc in mode 1.
REQ-031 SHALL reload the dwell counter on every state or inc change.

Reset
REQ-032 SHALL, on rst, go to IDLE and clear inc, inc_valid, busy, done, cfg_err, all config registers, the config-valid flag and the dwell counter.
REQ-033 SHALL give rst priority over abort, start and cfg handshake, including mid-sweep.

Structure
REQ-034 SHALL place the state encoding, PW/DWW defaults and mode constants in shared package dds_pkg.
REQ-035 SHALL implement the dwell counter as the sub-module dds_dwell_timer (load, count, expiry pulse).
REQ-036 SHALL register inc and inc_valid with no combinational path from inputs to outputs except cfg_ready.

Verification
REQ-037 SHALL cover: cfg start=10, stop=16, step=3, dwell=1, mode 0, then start -> inc 10,10,13,13,16,16, then done pulse, inc_valid=0, IDLE.
REQ-038 SHALL cover: mode 1, start=2, stop=8, step=4, dwell=0 -> inc 2,6,8,4,2,6,8, repeating.
REQ-039 SHALL cover: cfg_step=0 accepted -> cfg_err=1, and a later start is ignored with inc_valid held at 0.
REQ-040 SHALL cover: abort asserted mid-UP together with start -> next cycle IDLE, inc=0, done never asserted.
REQ-041 SHALL cover: rst asserted mid-DOWN -> next cycle all outputs 0, cfg_ready=1, and start is ignored until a new config is accepted.
REQ-042 SHALL cover: cfg_valid held high during a sweep -> not accepted until IDLE, with cfg_ready=0 throughout.
